// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, register index width and a scoreboard helper.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // x0 is hardwired, so it can never be busy regardless of the pending vector.
    function automatic logic reg_busy(input reg_idx_t idx, input logic [NUM_REGS-1:0] pend);
        return (idx != '0) && pend[idx];
    endfunction

endpackage

// File: rtl/cpu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last granted index, with wrap.
module cpu_rr_arbiter #(
    parameter int N = 3
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        o_grant = '0;
        last_d  = last_q;
        found   = 1'b0;
        cand    = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(last_q) + off) % N);
            if (!found && i_req[cand]) begin
                found         = 1'b1;
                o_grant[cand] = 1'b1;
                last_d        = cand;
            end
        end
    end

    // Pointer resets to the top index so requester 0 wins the first search.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            last_q <= IDX_W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cpu_regfile_arbiter.sv
// Register-file controller: round-robin writeback, pending-destination scoreboard, read hazard gating.
// Optional write-to-read bypass of the output stage is enabled by defining CPU_REGFILE_BYPASS_EN.
module cpu_regfile_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [NUM_REQ-1:0]             i_wb_valid,
    input  logic [NUM_REQ*REG_IDX_W-1:0]   i_wb_rd_idx,
    input  logic [NUM_REQ*XLEN-1:0]        i_wb_rd,
    output logic [NUM_REQ-1:0]             o_wb_ready,
    input  logic                           i_issue_valid,
    input  logic [REG_IDX_W-1:0]           i_issue_rd_idx,
    output logic                           o_issue_ready,
    input  logic                           i_read_req,
    input  logic [REG_IDX_W-1:0]           i_read_rs1_idx,
    input  logic [REG_IDX_W-1:0]           i_read_rs2_idx,
    output logic                           o_read_stall,
    output logic                           o_read_valid,
    output logic [XLEN-1:0]                o_rs1,
    output logic [XLEN-1:0]                o_rs2,
    output logic                           o_read,
    output logic [REG_IDX_W-1:0]           o_read_rs1_idx,
    output logic [REG_IDX_W-1:0]           o_read_rs2_idx,
    input  logic [XLEN-1:0]                i_rs1,
    input  logic [XLEN-1:0]                i_rs2,
    output logic                           o_write,
    output logic [REG_IDX_W-1:0]           o_write_rd_idx,
    output logic [XLEN-1:0]                o_rd
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                write_q, write_d;
    reg_idx_t            wr_idx_q, wr_idx_d;
    logic [XLEN-1:0]     wr_data_q, wr_data_d;
    logic                read_valid_q, read_valid_d;

    logic [NUM_REQ-1:0]  wb_req, wb_grant;
    reg_idx_t            sel_idx;
    logic [XLEN-1:0]     sel_data;
    logic                haz_rs1, haz_rs2, read_ok, issue_take;

    assign wb_req = i_wb_valid & {NUM_REQ{~i_reset}};

    cpu_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_req   (wb_req),
        .o_grant (wb_grant)
    );

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (wb_grant[k]) begin
                sel_idx  = i_wb_rd_idx[k*REG_IDX_W +: REG_IDX_W];
                sel_data = i_wb_rd[k*XLEN +: XLEN];
            end
        end
    end

`ifdef CPU_REGFILE_BYPASS_EN
    logic            byp_rs1_q, byp_rs1_d, byp_rs2_q, byp_rs2_d;
    logic [XLEN-1:0] byp_data_q, byp_data_d;

    // A register whose write is sitting in the output stage is forwarded instead of stalled.
    assign haz_rs1 = reg_busy(i_read_rs1_idx, pending_q) && !(write_q && wr_idx_q == i_read_rs1_idx);
    assign haz_rs2 = reg_busy(i_read_rs2_idx, pending_q) && !(write_q && wr_idx_q == i_read_rs2_idx);

    always_comb begin
        byp_rs1_d  = o_read && write_q && (wr_idx_q == i_read_rs1_idx);
        byp_rs2_d  = o_read && write_q && (wr_idx_q == i_read_rs2_idx);
        byp_data_d = wr_data_q;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            byp_rs1_q  <= 1'b0;
            byp_rs2_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_rs1_q  <= byp_rs1_d;
            byp_rs2_q  <= byp_rs2_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign o_rs1 = byp_rs1_q ? byp_data_q : i_rs1;
    assign o_rs2 = byp_rs2_q ? byp_data_q : i_rs2;
`else
    assign haz_rs1 = reg_busy(i_read_rs1_idx, pending_q);
    assign haz_rs2 = reg_busy(i_read_rs2_idx, pending_q);
    assign o_rs1   = i_rs1;
    assign o_rs2   = i_rs2;
`endif

    assign read_ok        = !(haz_rs1 || haz_rs2);
    assign o_read         = !i_reset && i_read_req && read_ok;
    assign o_read_stall   = !i_reset && i_read_req && !read_ok;
    assign o_read_rs1_idx = i_read_rs1_idx;
    assign o_read_rs2_idx = i_read_rs2_idx;

    assign o_issue_ready  = !i_reset && !reg_busy(i_issue_rd_idx, pending_q);
    assign issue_take     = i_issue_valid && o_issue_ready;

    assign o_wb_ready     = wb_grant;
    assign o_write        = write_q;
    assign o_write_rd_idx = wr_idx_q;
    assign o_rd           = wr_data_q;
    assign o_read_valid   = read_valid_q;

    always_comb begin
        pending_d = pending_q;
        if (write_q) begin
            pending_d[wr_idx_q] = 1'b0;
        end
        // Applied after the clear so a same-edge issue to the same register keeps it pending.
        if (issue_take) begin
            pending_d[i_issue_rd_idx] = 1'b1;
        end
        pending_d[0] = 1'b0;

        write_d      = (|wb_grant) && (sel_idx != '0);
        wr_idx_d     = (|wb_grant) ? sel_idx  : wr_idx_q;
        wr_data_d    = (|wb_grant) ? sel_data : wr_data_q;
        read_valid_d = o_read;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            pending_q    <= '0;
            write_q      <= 1'b0;
            wr_idx_q     <= '0;
            wr_data_q    <= '0;
            read_valid_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            write_q      <= write_d;
            wr_idx_q     <= wr_idx_d;
            wr_data_q    <= wr_data_d;
            read_valid_q <= read_valid_d;
        end
    end

endmodule

// File: tb/tb_cpu_regfile_arbiter.sv
// Self-checking bench for cpu_regfile_arbiter; expected writes flow through a scoreboard queue.
module tb_cpu_regfile_arbiter;

    localparam int NUM_REQ = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    i_wb_valid;
    logic [NUM_REQ*5-1:0]  i_wb_rd_idx;
    logic [NUM_REQ*32-1:0] i_wb_rd;
    logic [NUM_REQ-1:0]    o_wb_ready;
    logic                  i_issue_valid;
    logic [4:0]            i_issue_rd_idx;
    logic                  o_issue_ready;
    logic                  i_read_req;
    logic [4:0]            i_read_rs1_idx, i_read_rs2_idx;
    logic                  o_read_stall, o_read_valid, o_read;
    logic [31:0]           o_rs1, o_rs2, i_rs1, i_rs2;
    logic [4:0]            o_read_rs1_idx, o_read_rs2_idx;
    logic                  o_write;
    logic [4:0]            o_write_rd_idx;
    logic [31:0]           o_rd;

    always #5 clk = ~clk;

    cpu_regfile_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_wb_valid     (i_wb_valid),
        .i_wb_rd_idx    (i_wb_rd_idx),
        .i_wb_rd        (i_wb_rd),
        .o_wb_ready     (o_wb_ready),
        .i_issue_valid  (i_issue_valid),
        .i_issue_rd_idx (i_issue_rd_idx),
        .o_issue_ready  (o_issue_ready),
        .i_read_req     (i_read_req),
        .i_read_rs1_idx (i_read_rs1_idx),
        .i_read_rs2_idx (i_read_rs2_idx),
        .o_read_stall   (o_read_stall),
        .o_read_valid   (o_read_valid),
        .o_rs1          (o_rs1),
        .o_rs2          (o_rs2),
        .o_read         (o_read),
        .o_read_rs1_idx (o_read_rs1_idx),
        .o_read_rs2_idx (o_read_rs2_idx),
        .i_rs1          (i_rs1),
        .i_rs2          (i_rs2),
        .o_write        (o_write),
        .o_write_rd_idx (o_write_rd_idx),
        .o_rd           (o_rd)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  model_last;

    task automatic idle_inputs();
        i_wb_valid     = '0;
        i_wb_rd_idx    = '0;
        i_wb_rd        = '0;
        i_issue_valid  = 1'b0;
        i_issue_rd_idx = '0;
        i_read_req     = 1'b0;
        i_read_rs1_idx = '0;
        i_read_rs2_idx = '0;
        i_rs1          = '0;
        i_rs2          = '0;
    endtask

    task automatic set_wb(input int k, input logic [4:0] idx, input logic [31:0] d);
        i_wb_rd_idx[k*5 +: 5]  = idx;
        i_wb_rd[k*32 +: 32]    = d;
    endtask

    // Round-robin reference: pick the expected grant and queue the write it should produce.
    task automatic predict_grant(output logic [NUM_REQ-1:0] g);
        int c;
        g = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            c = (model_last + off) % NUM_REQ;
            if (g == '0 && i_wb_valid[c]) begin
                g[c]       = 1'b1;
                model_last = c;
                if (i_wb_rd_idx[c*5 +: 5] != 5'd0)
                    exp_q.push_back('{idx: i_wb_rd_idx[c*5 +: 5], data: i_wb_rd[c*32 +: 32]});
                $display("grant req%0d rd=x%0d data=%h", c, i_wb_rd_idx[c*5 +: 5], i_wb_rd[c*32 +: 32]);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst            = 1'b1;
        i_wb_valid     = '1;
        i_issue_valid  = 1'b1;
        i_issue_rd_idx = 5'd3;
        i_read_req     = 1'b1;
        i_read_rs1_idx = 5'd1;
        i_rs1          = 32'hA5A5_0001;
        i_rs2          = 32'h5A5A_0002;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({o_wb_ready, o_issue_ready, o_read, o_read_stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_comb: ready/issue/read/stall=%b required 0", {o_wb_ready, o_issue_ready, o_read, o_read_stall});
        end
        n_checks++;
        if (o_write !== 1'b0 || o_write_rd_idx !== 5'd0 || o_rd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_write: write=%b idx=%0d rd=%h required 0/0/0", o_write, o_write_rd_idx, o_rd);
        end
        n_checks++;
        if (o_read_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read_valid: got %b required 0", o_read_valid);
        end
        n_checks++;
        if (o_rs1 !== 32'hA5A5_0001 || o_rs2 !== 32'h5A5A_0002) begin
            n_fail++;
            $display("FAIL reset_passthru: rs1=%h rs2=%h required a5a50001/5a5a0002", o_rs1, o_rs2);
        end
        idle_inputs();
        @(negedge clk);
        rst        = 1'b0;
        model_last = NUM_REQ - 1;
        $display("reset released");
    endtask

    task automatic test_issue_hazard();
        logic [NUM_REQ-1:0] eg;
        wr_t e;
        @(negedge clk);
        i_issue_valid  = 1'b1;
        i_issue_rd_idx = 5'd5;
        #1;
        n_checks++;
        if (o_issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_x5: ready=%b required 1", o_issue_ready);
        end
        @(negedge clk);
        i_issue_valid  = 1'b0;
        i_read_req     = 1'b1;
        i_read_rs1_idx = 5'd5;
        i_read_rs2_idx = 5'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (o_read_stall !== 1'b1 || o_read !== 1'b0) begin
                n_fail++;
                $display("FAIL hazard_stall[%0d]: stall=%b read=%b required 1/0", i, o_read_stall, o_read);
            end
            @(negedge clk);
        end
        i_read_req = 1'b0;
        i_wb_valid = 3'b001;
        set_wb(0, 5'd5, 32'h0000_0055);
        #1;
        predict_grant(eg);
        n_checks++;
        if (o_wb_ready !== eg) begin
            n_fail++;
            $display("FAIL hazard_grant: got %b required %b", o_wb_ready, eg);
        end
        @(negedge clk);
        i_wb_valid = '0;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL hazard_wb: scoreboard empty, write=%b", o_write);
        end else begin
            e = exp_q.pop_front();
            if (o_write !== 1'b1 || o_write_rd_idx !== e.idx || o_rd !== e.data) begin
                n_fail++;
                $display("FAIL hazard_wb: write=%b x%0d=%h required 1 x%0d=%h", o_write, o_write_rd_idx, o_rd, e.idx, e.data);
            end
        end
        @(negedge clk);
        i_read_req     = 1'b1;
        i_read_rs1_idx = 5'd5;
        i_read_rs2_idx = 5'd5;
        i_rs1          = 32'h0000_0055;
        i_rs2          = 32'h0000_0055;
        #1;
        n_checks++;
        if (o_read !== 1'b1 || o_read_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_release: read=%b stall=%b required 1/0", o_read, o_read_stall);
        end
        @(negedge clk);
        i_read_req = 1'b0;
        n_checks++;
        if (o_read_valid !== 1'b1 || o_rs1 !== 32'h55 || o_rs2 !== 32'h55) begin
            n_fail++;
            $display("FAIL hazard_data: valid=%b rs1=%h rs2=%h required 1/55/55", o_read_valid, o_rs1, o_rs2);
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] eg;
        wr_t e;
        set_wb(0, 5'd1, 32'h0000_0100);
        set_wb(1, 5'd2, 32'h0000_0101);
        set_wb(2, 5'd3, 32'h0000_0102);
        i_wb_valid = '1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (i == 6) i_wb_valid = '0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rr_wb[%0d]: scoreboard empty, write=%b", i, o_write);
                end else begin
                    e = exp_q.pop_front();
                    if (o_write !== 1'b1 || o_write_rd_idx !== e.idx || o_rd !== e.data) begin
                        n_fail++;
                        $display("FAIL rr_wb[%0d]: write=%b x%0d=%h required 1 x%0d=%h", i, o_write, o_write_rd_idx, o_rd, e.idx, e.data);
                    end
                end
            end
            if (i < 6) begin
                #1;
                predict_grant(eg);
                n_checks++;
                if (o_wb_ready !== eg) begin
                    n_fail++;
                    $display("FAIL rr_grant[%0d]: got %b required %b", i, o_wb_ready, eg);
                end
            end
        end
    endtask

    task automatic test_x0_write();
        logic [NUM_REQ-1:0] eg;
        i_wb_valid = 3'b010;
        set_wb(1, 5'd0, 32'h0000_DEAD);
        #1;
        predict_grant(eg);
        n_checks++;
        if (o_wb_ready !== eg || o_wb_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_grant: got %b required %b", o_wb_ready, eg);
        end
        @(negedge clk);
        i_wb_valid = '0;
        n_checks++;
        if (o_write !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_no_write: write=%b idx=%0d required write 0", o_write, o_write_rd_idx);
        end
    endtask

    task automatic test_bypass();
        logic [NUM_REQ-1:0] eg;
        wr_t e;
        @(negedge clk);
        i_issue_valid  = 1'b1;
        i_issue_rd_idx = 5'd7;
        #1;
        n_checks++;
        if (o_issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_x7: ready=%b required 1", o_issue_ready);
        end
        @(negedge clk);
        i_issue_valid = 1'b0;
        i_wb_valid    = 3'b001;
        set_wb(0, 5'd7, 32'h0000_1234);
        #1;
        predict_grant(eg);
        n_checks++;
        if (o_wb_ready !== eg) begin
            n_fail++;
            $display("FAIL byp_grant: got %b required %b", o_wb_ready, eg);
        end
        @(negedge clk);
        i_wb_valid = '0;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL byp_wb: scoreboard empty, write=%b", o_write);
        end else begin
            e = exp_q.pop_front();
            if (o_write !== 1'b1 || o_write_rd_idx !== e.idx || o_rd !== e.data) begin
                n_fail++;
                $display("FAIL byp_wb: write=%b x%0d=%h required 1 x%0d=%h", o_write, o_write_rd_idx, o_rd, e.idx, e.data);
            end
        end
        i_read_req     = 1'b1;
        i_read_rs1_idx = 5'd7;
        i_read_rs2_idx = 5'd0;
        i_rs1          = 32'hBAD0_0000;
        #1;
`ifdef CPU_REGFILE_BYPASS_EN
        n_checks++;
        if (o_read !== 1'b1 || o_read_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL byp_accept: read=%b stall=%b required 1/0", o_read, o_read_stall);
        end
        @(negedge clk);
        i_read_req = 1'b0;
`else
        n_checks++;
        if (o_read !== 1'b0 || o_read_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL byp_stall: read=%b stall=%b required 0/1", o_read, o_read_stall);
        end
        @(negedge clk);
        n_checks++;
        if (o_read_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL byp_no_valid: valid=%b required 0", o_read_valid);
        end
        i_rs1 = 32'h0000_1234;
        #1;
        n_checks++;
        if (o_read !== 1'b1 || o_read_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL byp_retry: read=%b stall=%b required 1/0", o_read, o_read_stall);
        end
        @(negedge clk);
        i_read_req = 1'b0;
`endif
        n_checks++;
        if (o_read_valid !== 1'b1 || o_rs1 !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL byp_data: valid=%b rs1=%h required 1/00001234", o_read_valid, o_rs1);
        end
        $display("read x7 -> %h", o_rs1);
    endtask

    task automatic test_back_to_back();
        logic [NUM_REQ-1:0] eg;
        wr_t e;
        @(negedge clk);
        i_issue_valid  = 1'b1;
        i_issue_rd_idx = 5'd9;
        #1;
        n_checks++;
        if (o_issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_first: ready=%b required 1", o_issue_ready);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (o_issue_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL waw_refuse[%0d]: ready=%b required 0", i, o_issue_ready);
            end
        end
        @(negedge clk);
        i_wb_valid = 3'b100;
        set_wb(2, 5'd9, 32'h0000_0099);
        #1;
        predict_grant(eg);
        n_checks++;
        if (o_wb_ready !== eg || o_issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_grant: grant=%b ready=%b required %b/0", o_wb_ready, o_issue_ready, eg);
        end
        @(negedge clk);
        i_wb_valid = '0;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL waw_wb: scoreboard empty, write=%b", o_write);
        end else begin
            e = exp_q.pop_front();
            if (o_write !== 1'b1 || o_write_rd_idx !== e.idx || o_rd !== e.data) begin
                n_fail++;
                $display("FAIL waw_wb: write=%b x%0d=%h required 1 x%0d=%h", o_write, o_write_rd_idx, o_rd, e.idx, e.data);
            end
        end
        #1;
        n_checks++;
        if (o_issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_write_cycle: ready=%b required 0", o_issue_ready);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (o_issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_after: ready=%b required 1", o_issue_ready);
        end
        i_issue_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [NUM_REQ-1:0] eg;
        wr_t e;
        @(negedge clk);
        i_issue_valid  = 1'b1;
        i_issue_rd_idx = 5'd11;
        #1;
        n_checks++;
        if (o_issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_x11: ready=%b required 1", o_issue_ready);
        end
        @(negedge clk);
        i_issue_valid = 1'b0;
        i_wb_valid    = 3'b010;
        set_wb(1, 5'd4, 32'h0000_0044);
        #1;
        predict_grant(eg);
        n_checks++;
        if (o_wb_ready !== eg) begin
            n_fail++;
            $display("FAIL mid_grant: got %b required %b", o_wb_ready, eg);
        end
        @(negedge clk);
        i_wb_valid = '0;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL mid_wb: scoreboard empty, write=%b", o_write);
        end else begin
            e = exp_q.pop_front();
            if (o_write !== 1'b1 || o_write_rd_idx !== e.idx || o_rd !== e.data) begin
                n_fail++;
                $display("FAIL mid_wb: write=%b x%0d=%h required 1 x%0d=%h", o_write, o_write_rd_idx, o_rd, e.idx, e.data);
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (o_write !== 1'b0 || o_write_rd_idx !== 5'd0 || o_rd !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: write=%b idx=%0d rd=%h required 0/0/0", o_write, o_write_rd_idx, o_rd);
        end
        @(negedge clk);
        rst        = 1'b0;
        model_last = NUM_REQ - 1;
        $display("reset mid-operation released");
        i_wb_valid = '1;
        set_wb(0, 5'd0, 32'h0);
        set_wb(1, 5'd0, 32'h0);
        set_wb(2, 5'd0, 32'h0);
        i_read_req     = 1'b1;
        i_read_rs1_idx = 5'd11;
        i_read_rs2_idx = 5'd0;
        #1;
        predict_grant(eg);
        n_checks++;
        if (o_wb_ready !== eg || o_wb_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL post_reset_grant: got %b required %b", o_wb_ready, eg);
        end
        n_checks++;
        if (o_read !== 1'b1 || o_read_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_sb: read=%b stall=%b required 1/0", o_read, o_read_stall);
        end
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (o_write !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_x0: write=%b required 0", o_write);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_issue_hazard();
        test_round_robin();
        test_x0_write();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
